// File: rtl/tetris_playfield_if.sv
// Display-read, piece-write and line-clear signals between the game logic and the playfield.
interface tetris_playfield_if #(parameter int TYPE_W = 3);
  logic [3:0]        rd_x;
  logic [4:0]        rd_y;
  logic [TYPE_W-1:0] rd_type;
  logic              wr_en;
  logic [3:0]        wr_x;
  logic [4:0]        wr_y;
  logic [TYPE_W-1:0] wr_type;
  logic              clear_start;
  logic              busy;
  logic              done;
  logic [4:0]        lines_cleared;
  logic [15:0]       total_lines;

  modport master (
    output rd_x, rd_y, wr_en, wr_x, wr_y, wr_type, clear_start,
    input  rd_type, busy, done, lines_cleared, total_lines
  );
  modport slave (
    input  rd_x, rd_y, wr_en, wr_x, wr_y, wr_type, clear_start,
    output rd_type, busy, done, lines_cleared, total_lines
  );
endinterface

// File: rtl/tetris_playfield.sv
// 10x20 Tetris board store with a registered read port, single-cell writes
// and a bottom-up scan/shift engine that removes full rows.
module tetris_playfield #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 20,
  parameter int TYPE_W = 3
) (
  input logic           clk,
  input logic           reset_n,
  tetris_playfield_if.slave pf
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef logic [WIDTH-1:0][TYPE_W-1:0] row_t;

  row_t [HEIGHT-1:0] board;
  logic [1:0]        state;
  logic [4:0]        r;
  logic [4:0]        pass_cnt;
  logic              row_full;
  logic              wr_ok;
  logic              rd_ok;

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < WIDTH; c++)
      if (board[r][c] == '0) row_full = 1'b0;
  end

  assign wr_ok = pf.wr_en && (state == S_IDLE) &&
                 (32'(pf.wr_x) < WIDTH) && (32'(pf.wr_y) < HEIGHT);
  assign rd_ok = (32'(pf.rd_x) < WIDTH) && (32'(pf.rd_y) < HEIGHT);

  assign pf.busy = (state != S_IDLE);
  assign pf.done = (state == S_DONE);

  // Shift and write are mutually exclusive: writes only land in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      board <= '0;
    end else if (state == S_SHIFT) begin
      board[0] <= '0;
      for (int i = 1; i < HEIGHT; i++)
        if (i <= int'(r)) board[i] <= board[i-1];
    end else if (wr_ok) begin
      board[pf.wr_y][pf.wr_x] <= pf.wr_type;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pf.rd_type <= '0;
    else          pf.rd_type <= rd_ok ? board[pf.rd_y][pf.rd_x] : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      r                <= '0;
      pass_cnt         <= '0;
      pf.lines_cleared <= '0;
      pf.total_lines   <= '0;
    end else begin
      case (state)
        S_IDLE: if (pf.clear_start) begin
          state    <= S_SCAN;
          r        <= 5'(HEIGHT - 1);
          pass_cnt <= '0;
        end
        S_SCAN: begin
          if (row_full) begin
            state <= S_SHIFT;
          end else if (r == '0) begin
            // Latched on entry to DONE so the count is valid alongside the done pulse.
            state            <= S_DONE;
            pf.lines_cleared <= pass_cnt;
          end else begin
            r <= r - 5'd1;
          end
        end
        S_SHIFT: begin
          state          <= S_SCAN;
          pass_cnt       <= pass_cnt + 5'd1;
          pf.total_lines <= pf.total_lines + 16'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tetris_playfield.sv
// Randomized and directed checks of tetris_playfield against a row-filter board model.
module tb_tetris_playfield;
  localparam int W = 10;
  localparam int H = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tetris_playfield_if #(.TYPE_W(3)) pf();
  tetris_playfield #(.WIDTH(W), .HEIGHT(H), .TYPE_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .pf(pf)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int bm [H][W];
  int m_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (bm[y, x]) bm[y][x] = 0;
    m_total = 0;
  endtask

  // Keep non-full rows in order, packed to the bottom; return number removed.
  task automatic model_clear(output int k);
    int nb [H][W];
    int dst;
    bit full;
    k = 0;
    dst = H - 1;
    foreach (nb[y, x]) nb[y][x] = 0;
    for (int y = H - 1; y >= 0; y--) begin
      full = 1;
      for (int x = 0; x < W; x++) if (bm[y][x] == 0) full = 0;
      if (full) k++;
      else begin
        for (int x = 0; x < W; x++) nb[dst][x] = bm[y][x];
        dst--;
      end
    end
    bm = nb;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic wr(input int x, input int y, input int t);
    pf.wr_x = 4'(x); pf.wr_y = 5'(y); pf.wr_type = 3'(t); pf.wr_en = 1'b1;
    @(negedge clk);
    pf.wr_en = 1'b0;
    if (x < W && y < H) bm[y][x] = t;
  endtask

  task automatic rd_chk(input string tag, input int x, input int y, input int exp);
    pf.rd_x = 4'(x); pf.rd_y = 5'(y);
    @(negedge clk);
    chk(tag, 32'(pf.rd_type), exp);
  endtask

  task automatic sweep(input string tag);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) rd_chk(tag, x, y, bm[y][x]);
  endtask

  task automatic fill_row(input int y, input int t);
    for (int x = 0; x < W; x++) wr(x, y, t);
  endtask

  // mode 0: plain; 1: write together with clear_start; 2: write attempted while busy
  task automatic run_pass(input string tag, input int mode, input int wx, input int wy, input int wt);
    int k, cyc, dn, dcyc, lc;
    cyc = 0; dn = 0; dcyc = -1; lc = -1;
    pf.clear_start = 1'b1;
    if (mode == 1) begin
      pf.wr_x = 4'(wx); pf.wr_y = 5'(wy); pf.wr_type = 3'(wt); pf.wr_en = 1'b1;
      bm[wy][wx] = wt;
    end
    @(negedge clk);
    pf.clear_start = 1'b0;
    pf.wr_en = 1'b0;
    model_clear(k);
    m_total = (m_total + k) % 65536;
    while (pf.busy && cyc < 200) begin
      cyc++;
      if (pf.done) begin dn++; dcyc = cyc; lc = int'(pf.lines_cleared); end
      if (mode == 2 && cyc == 3) begin
        pf.wr_x = 4'(wx); pf.wr_y = 5'(wy); pf.wr_type = 3'(wt); pf.wr_en = 1'b1;
      end else pf.wr_en = 1'b0;
      @(negedge clk);
    end
    pf.wr_en = 1'b0;
    chk({tag, "_busy_cycles"}, cyc, H + 2 * k + 1);
    chk({tag, "_done_count"}, dn, 1);
    chk({tag, "_done_last"}, dcyc, cyc);
    chk({tag, "_lines"}, lc, k);
    chk({tag, "_lines_held"}, 32'(pf.lines_cleared), k);
    chk({tag, "_total"}, 32'(pf.total_lines), m_total);
  endtask

  initial begin
    pf.rd_x = '0; pf.rd_y = '0; pf.wr_en = 1'b0; pf.wr_x = '0; pf.wr_y = '0;
    pf.wr_type = '0; pf.clear_start = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_rd_type", 32'(pf.rd_type), 0);
    chk("rst_busy", 32'(pf.busy), 0);
    chk("rst_done", 32'(pf.done), 0);
    chk("rst_lines", 32'(pf.lines_cleared), 0);
    chk("rst_total", 32'(pf.total_lines), 0);
    reset_n = 1'b1;
    @(negedge clk);

    sweep("empty_sweep");
    rd_chk("oor_x", 10, 0, 0);
    rd_chk("oor_y", 0, 20, 0);
    run_pass("empty", 0, 0, 0, 0);

    // Read latency: write cycle N, data on rd_type after edge N+1.
    pf.rd_x = 4'd3; pf.rd_y = 5'd7;
    pf.wr_x = 4'd3; pf.wr_y = 5'd7; pf.wr_type = 3'd5; pf.wr_en = 1'b1;
    @(negedge clk);
    pf.wr_en = 1'b0;
    bm[7][3] = 5;
    chk("wr_lat1", 32'(pf.rd_type), 0);
    @(negedge clk);
    chk("wr_lat2", 32'(pf.rd_type), 5);
    rd_chk("wr_neighbour", 4, 7, 0);

    do_reset();
    fill_row(19, 1);
    wr(0, 18, 2);
    rd_chk("oor_x_full", 10, 19, 0);
    rd_chk("oor_y_full", 9, 20, 0);
    wr(10, 19, 6);
    wr(0, 20, 6);
    run_pass("one_row", 0, 0, 0, 0);
    rd_chk("one_row_drop", 0, 19, 2);
    sweep("one_row_sweep");

    do_reset();
    fill_row(19, 1);
    fill_row(17, 6);
    wr(4, 18, 3);
    run_pass("two_rows", 0, 0, 0, 0);
    rd_chk("two_rows_drop", 4, 19, 3);
    sweep("two_rows_sweep");

    do_reset();
    fill_row(0, 4);
    run_pass("row0", 2, 2, 2, 7);
    sweep("row0_sweep");

    do_reset();
    for (int x = 0; x < W - 1; x++) wr(x, 19, 2);
    run_pass("wr_and_start", 1, W - 1, 19, 4);
    sweep("wr_and_start_sweep");

    // Asynchronous reset in the middle of a pass.
    do_reset();
    fill_row(19, 3);
    fill_row(18, 5);
    pf.rd_x = 4'd0; pf.rd_y = 5'd19;
    pf.clear_start = 1'b1;
    @(negedge clk);
    pf.clear_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_total_pre", 32'(pf.total_lines), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(pf.busy), 0);
    chk("mid_rst_done", 32'(pf.done), 0);
    chk("mid_rst_lines", 32'(pf.lines_cleared), 0);
    chk("mid_rst_total", 32'(pf.total_lines), 0);
    chk("mid_rst_rd", 32'(pf.rd_type), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    sweep("mid_rst_sweep");
    run_pass("after_rst", 0, 0, 0, 0);

    // Random boards, two passes each so total_lines accumulates.
    for (int it = 0; it < 5; it++) begin
      do_reset();
      for (int y = 0; y < H; y++) begin
        bit full_row;
        full_row = ($urandom_range(2) == 0);
        for (int x = 0; x < W; x++) begin
          int t;
          t = (full_row || $urandom_range(1) == 1) ? int'($urandom_range(7, 1)) : 0;
          if (t != 0) wr(x, y, t);
        end
      end
      run_pass("rnd", 0, 0, 0, 0);
      sweep("rnd_sweep");
      for (int n = 0; n < 3; n++) fill_row($urandom_range(H - 1), $urandom_range(7, 1));
      run_pass("rnd2", 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
